key_event_reg: RTL
==================

KEY_EVENT_REG -- requirements
Module: key_event_reg

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 16, number of key input channels (2..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, key-code FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, single clock; all logic is rising-edge clk.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port key_clear, input, 1, synchronous clear of all latched state.
REQ-006 SHALL have port key_pulse, input, NUM_KEYS, per-key pulse/level, already synchronous to clk.
REQ-007 SHALL have port key_reg, output, NUM_KEYS, sticky per-key pressed flags.
REQ-008 SHALL have port code_data, output, CW = $clog2(NUM_KEYS), index of the oldest queued key event.
REQ-009 SHALL have port code_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port code_ready, input, 1, consumer pop; a pop occurs when code_valid and code_ready are both high.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of queued codes.
REQ-012 SHALL have port overflow, output, 1, sticky event-lost flag.

Function
REQ-013 SHALL register key_pulse into prev each cycle; edge[i] = key_pulse[i] & ~prev[i].
REQ-014 SHALL set key_reg[i] on the cycle after edge[i]; key_reg[i] stays set until key_clear or rst.
REQ-015 SHALL keep a pending mask; the candidate set each cycle is pend = pending | edge.
REQ-016 SHALL select the lowest set index of pend each cycle (fixed priority, index 0 highest); when a push is allowed, it SHALL write that index into the FIFO and clear the bit from pending. All other bits of pend SHALL be retained in pending.
REQ-017 SHALL allow a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 SHALL give an isolated edge in cycle t a response of key_reg set and code_valid high with the matching code_data after the clk edge that ends cycle t (latency 1), provided the FIFO was empty.
REQ-019 SHALL, when the FIFO is full and no pop occurs, push nothing; pending SHALL hold the events without loss.
REQ-020 SHALL set overflow when edge[i] occurs while pending[i] is already set and is not being pushed in that cycle; the merged event is lost.
REQ-021 SHALL make code_data the FIFO head; code_data SHALL remain stable while code_valid is high and no pop occurs.
REQ-022 SHALL make fifo_count reflect pushes and pops of the previous cycle; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 SHALL have key_clear clear key_reg, pending, the FIFO and overflow on the next edge. key_clear SHALL take priority over same-cycle edges and pops, which are discarded. prev SHALL still update.
REQ-024 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-025 SHALL, with rst high, clear key_reg, pending, FIFO pointers, fifo_count, overflow and code_valid to 0, and hold code_data at 0.
REQ-026 SHALL load prev with key_pulse during rst, so keys held through reset release produce no event.
REQ-027 SHALL give rst priority over key_clear and all other activity, including mid-drain and a full FIFO.

Configuration
REQ-028 SHALL, with macro KEY_MASK_EN defined, add input key_mask (width NUM_KEYS, 1 = enabled). edge[i] SHALL be gated by key_mask[i], so masked keys never set key_reg, pending or overflow. Already-latched state is unaffected by later masking.
REQ-029 SHALL, with KEY_MASK_EN undefined, have no key_mask port, and all keys SHALL be enabled.

Verification
REQ-030 SHALL cover: key_pulse[5] rises at t with the FIFO empty -> key_reg=0x0020, code_valid=1, code_data=5 at t+1; pop -> code_valid=0, fifo_count=0.
REQ-031 SHALL cover: keys 3, 9 and 12 rise in the same cycle with code_ready=1 -> codes 3, 9, 12 on consecutive cycles, key_reg=0x1208.
REQ-032 SHALL cover: code_ready=0 with 6 distinct single edges, FIFO_DEPTH=4 -> fifo_count=4, 2 events pending, overflow=0; then release code_ready -> all 6 codes in priority/arrival order.
REQ-033 SHALL cover: key 2 queued pending behind a full FIFO, and key 2 rises again -> overflow=1, only one code 2 delivered.
REQ-034 SHALL cover: key_clear asserted in the same cycle as key_pulse[7] rises, with fifo_count=3 -> next cycle key_reg=0, fifo_count=0, overflow=0, no code 7.
REQ-035 SHALL cover: key_pulse[0] held high across rst release -> no event; with KEY_MASK_EN and key_mask[4]=0, a key 4 edge -> key_reg[4]=0 and no code.

Source files
------------

// File: rtl/key_event_reg.sv
// rtl/key_event_reg.sv - sticky per-key flags plus a key-code FIFO fed by rising-edge events
// Optional per-key enable input is built when KEY_MASK_EN is defined.
module key_event_reg #(
    parameter int NUM_KEYS   = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int NW = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_clear,
    input  logic [NUM_KEYS-1:0] key_pulse,
`ifdef KEY_MASK_EN
    input  logic [NUM_KEYS-1:0] key_mask,
`endif
    output logic [NUM_KEYS-1:0] key_reg,
    output logic [CW-1:0]       code_data,
    output logic                code_valid,
    input  logic                code_ready,
    output logic [NW-1:0]       fifo_count,
    output logic                overflow
);

    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] r_key_reg;
    logic [NUM_KEYS-1:0] r_pending;
    logic [CW-1:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [NW-1:0]       r_count;
    logic                r_overflow;

    logic [NUM_KEYS-1:0] w_edge;
    logic [NUM_KEYS-1:0] w_pend;
    logic [NUM_KEYS-1:0] w_taken;
    logic [CW-1:0]       w_sel;
    logic                w_any;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_lost;

`ifdef KEY_MASK_EN
    assign w_edge = key_pulse & ~r_prev & key_mask;
`else
    assign w_edge = key_pulse & ~r_prev;
`endif

    assign w_pend = r_pending | w_edge;

    // Fixed priority: scanning downward leaves the lowest set index selected.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel = CW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign code_valid = (r_count != '0);
    assign w_full     = (r_count == NW'(FIFO_DEPTH));
    assign w_pop      = code_valid & code_ready;
    assign w_push     = w_any & (~w_full | w_pop);
    assign w_taken    = w_push ? (NUM_KEYS'(1) << w_sel) : '0;
    // A repeat edge is only lost if its earlier instance is still waiting after this cycle.
    assign w_lost     = |(w_edge & r_pending & ~w_taken);

    // prev tracks key_pulse unconditionally so held keys never fake an edge after rst/clear.
    always_ff @(posedge clk) begin
        r_prev <= key_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            r_key_reg  <= '0;
            r_pending  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_key_reg <= r_key_reg | w_edge;
            r_pending <= w_pend & ~w_taken;
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !key_clear && w_push) begin
            r_mem[r_wr_ptr] <= w_sel;
        end
    end

    assign key_reg    = r_key_reg;
    assign code_data  = code_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
